// File: rtl/mem_access_pkg.sv
// Shared types for the memory-access stage: decoded instruction and operand
// structs, FSM state constants and the load/store size code.
package mem_access_pkg;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instructions;

  typedef struct packed {
    logic [31:0] rs1;
    logic [31:0] rs2;
  } regvpair;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Encoding mirrors funct3 so loads and stores share one decoder.
  typedef enum logic [2:0] {
    SZ_B  = 3'd0,
    SZ_H  = 3'd1,
    SZ_W  = 3'd2,
    SZ_BU = 3'd4,
    SZ_HU = 3'd5
  } size_e;

  function automatic size_e size_code(input logic [2:0] funct3);
    case (funct3)
      3'd0:    return SZ_B;
      3'd1:    return SZ_H;
      3'd4:    return SZ_BU;
      3'd5:    return SZ_HU;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    case (size)
      SZ_H, SZ_HU: return off[0];
      SZ_W:        return |off;
      default:     return 1'b0;
    endcase
  endfunction

  // Drops the low offset bits that an access of this size cannot address.
  function automatic logic [1:0] align_off(input size_e size, input logic [1:0] off);
    case (size)
      SZ_H, SZ_HU: return {off[1], 1'b0};
      SZ_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_lane.sv
// mem_lane: combinational byte-lane steering for stores (data replication,
// strobes) and lane extraction plus sign/zero extension for loads.
module mem_lane
  import mem_access_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  off,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  always_comb begin
    case (off)
      2'd0:    byte_s = load_word[7:0];
      2'd1:    byte_s = load_word[15:8];
      2'd2:    byte_s = load_word[23:16];
      default: byte_s = load_word[31:24];
    endcase
    if (off[1]) begin
      half_s = load_word[31:16];
    end else begin
      half_s = load_word[15:0];
    end
  end

  always_comb begin
    case (size)
      SZ_B, SZ_BU: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << off;
      end
      SZ_H, SZ_HU: begin
        wdata = {2{store_data[15:0]}};
        wstrb = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = store_data;
        wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (size)
      SZ_B:    load_data = {{24{byte_s[7]}}, byte_s};
      SZ_BU:   load_data = {24'd0, byte_s};
      SZ_H:    load_data = {{16{half_s[15]}}, half_s};
      SZ_HU:   load_data = {16'd0, half_s};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: load/store stage after the ALU, driving a req/gnt/rvalid data bus.
// Optional MEM_MISALIGN_TRAP_EN: report misaligned accesses instead of aligning them down.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enabled,
  input  instructions instr,
  input  regvpair     register,
  input  logic [31:0] alu_result,
  output logic        completed,
  output logic [31:0] result,
  output logic        load_misaligned,
  output logic        store_misaligned,
  output logic        bus_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_r;
  size_e            size_r;
  logic [1:0]       off_r;
  logic             is_load_r;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0]      done_val_r;
  logic             done_lmis_r;
  logic             done_smis_r;
  logic             done_berr_r;

  logic             is_load_s;
  logic             is_store_s;
  logic             mis_s;
  size_e            size_in_s;
  size_e            lane_size_s;
  logic [1:0]       lane_off_s;
  logic [31:0]      lane_wdata_s;
  logic [3:0]       lane_wstrb_s;
  logic [31:0]      lane_rdata_s;
  logic             unused_s;

  assign unused_s = ^{register.rs1, instr.funct7, instr.rs2, instr.rs1, instr.rd};

  // Decode the incoming instruction; the lane uses live inputs only while idle.
  always_comb begin
    is_load_s  = (instr.opcode == OPC_LOAD);
    is_store_s = (instr.opcode == OPC_STORE);
    size_in_s  = size_code(instr.funct3);
`ifdef MEM_MISALIGN_TRAP_EN
    mis_s      = misaligned(size_in_s, alu_result[1:0]);
`else
    mis_s      = 1'b0;
`endif
    if (state_r == ST_IDLE) begin
      lane_size_s = size_in_s;
      lane_off_s  = align_off(size_in_s, alu_result[1:0]);
    end else begin
      lane_size_s = size_r;
      lane_off_s  = off_r;
    end
  end

  mem_lane u_lane (
    .size       (lane_size_s),
    .off        (lane_off_s),
    .store_data (register.rs2),
    .load_word  (mem_rdata),
    .wdata      (lane_wdata_s),
    .wstrb      (lane_wstrb_s),
    .load_data  (lane_rdata_s)
  );

  // Access sequencer; completed is raised on the DONE->IDLE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r          <= ST_IDLE;
      size_r           <= SZ_B;
      off_r            <= 2'b00;
      is_load_r        <= 1'b0;
      cnt_r            <= '0;
      done_val_r       <= 32'd0;
      done_lmis_r      <= 1'b0;
      done_smis_r      <= 1'b0;
      done_berr_r      <= 1'b0;
      completed        <= 1'b0;
      result           <= 32'd0;
      load_misaligned  <= 1'b0;
      store_misaligned <= 1'b0;
      bus_error        <= 1'b0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= 32'd0;
      mem_wdata        <= 32'd0;
      mem_wstrb        <= 4'b0000;
    end else begin
      completed <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (enabled) begin
            size_r      <= size_in_s;
            off_r       <= lane_off_s;
            is_load_r   <= is_load_s;
            done_berr_r <= 1'b0;
            if (!(is_load_s || is_store_s)) begin
              done_val_r  <= alu_result;
              done_lmis_r <= 1'b0;
              done_smis_r <= 1'b0;
              state_r     <= ST_DONE;
            end else if (mis_s) begin
              done_val_r  <= 32'd0;
              done_lmis_r <= is_load_s;
              done_smis_r <= is_store_s;
              state_r     <= ST_DONE;
            end else begin
              done_lmis_r <= 1'b0;
              done_smis_r <= 1'b0;
              mem_req     <= 1'b1;
              mem_we      <= is_store_s;
              mem_addr    <= {alu_result[31:2], 2'b00};
              mem_wdata   <= is_store_s ? lane_wdata_s : 32'd0;
              mem_wstrb   <= is_store_s ? lane_wstrb_s : 4'b0000;
              state_r     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            cnt_r   <= '0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A response in the final timeout cycle still counts as a response.
          if (mem_rvalid) begin
            done_val_r <= is_load_r ? lane_rdata_s : 32'd0;
            state_r    <= ST_DONE;
          end else if (cnt_r == CNT_LAST) begin
            done_val_r  <= 32'd0;
            done_berr_r <= 1'b1;
            state_r     <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          completed        <= 1'b1;
          result           <= done_val_r;
          load_misaligned  <= done_lmis_r;
          store_misaligned <= done_smis_r;
          bus_error        <= done_berr_r;
          state_r          <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, reset-abort
// sequence, and randomized transactions scored against a behavioural model.
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int T = 255;

  typedef struct packed {
    logic [31:0] res;
    logic        lm;
    logic        sm;
    logic        be;
    logic [31:0] lat;
    logic        req;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  typedef struct {
    logic [31:0] iw;
    logic [31:0] rs2;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          gnt_lat;
    int          rv_lat;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        enabled;
  instructions instr_v;
  regvpair     reg_v;
  logic [31:0] alu_result;
  logic        completed;
  logic [31:0] result;
  logic        load_misaligned;
  logic        store_misaligned;
  logic        bus_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_access #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .enabled          (enabled),
    .instr            (instr_v),
    .register         (reg_v),
    .alu_result       (alu_result),
    .completed        (completed),
    .result           (result),
    .load_misaligned  (load_misaligned),
    .store_misaligned (store_misaligned),
    .bus_error        (bus_error),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wstrb        (mem_wstrb),
    .mem_gnt          (mem_gnt),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] enc(input logic [6:0] op, input logic [2:0] f3);
    return {17'd0, f3, 5'd1, op};
  endfunction

  function automatic exp_t mke(input logic [31:0] res, input logic [2:0] flags, input int lat,
                               input logic req, input logic [31:0] maddr, input logic we,
                               input logic [3:0] wstrb, input logic [31:0] wdata);
    exp_t e;
    e.res = res; {e.lm, e.sm, e.be} = flags; e.lat = 32'(lat);
    e.req = req; e.maddr = maddr; e.we = we; e.wstrb = wstrb; e.wdata = wdata;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] iw, input logic [31:0] rs2, input logic [31:0] addr,
                               input logic [31:0] rdata, input int gl, input int rl, input exp_t e);
    vec_t v;
    v.iw = iw; v.rs2 = rs2; v.addr = addr; v.rdata = rdata; v.gnt_lat = gl; v.rv_lat = rl; v.e = e;
    return v;
  endfunction

  // Behavioural expectation derived from the access rules with plain arithmetic.
  function automatic exp_t model(input vec_t v);
    exp_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    int          nb;
    int          idx;
    logic [31:0] mask;
    logic [31:0] val;
    bit          tmo;
    e  = '0;
    op = v.iw[6:0];
    f3 = v.iw[14:12];
    if (op != OPC_LOAD && op != OPC_STORE) begin
      e.res = v.addr; e.lat = 32'd2;
      return e;
    end
    nb  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    idx = int'(v.addr % 32'd4);
    if (idx % nb != 0) begin
`ifdef MEM_MISALIGN_TRAP_EN
      e.lat = 32'd2;
      if (op == OPC_LOAD) e.lm = 1'b1; else e.sm = 1'b1;
      return e;
`else
      idx = idx - idx % nb;
`endif
    end
    e.req   = 1'b1;
    e.we    = (op == OPC_STORE);
    e.maddr = v.addr & 32'hFFFF_FFFC;
    tmo     = (v.rv_lat < 0) || (v.rv_lat >= T);
    e.be    = tmo;
    e.lat   = 32'(4 + v.gnt_lat + (tmo ? T - 1 : v.rv_lat));
    mask    = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    if (e.we) begin
      e.wstrb = 4'(((1 << nb) - 1) << idx);
      e.wdata = (nb == 4) ? v.rs2 : (v.rs2 & mask) * ((nb == 1) ? 32'h0101_0101 : 32'h0001_0001);
    end else if (!tmo) begin
      val = (v.rdata >> (8 * idx)) & mask;
      if (!f3[2] && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
      e.res = val;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic rst_check(input string tag);
    chk({tag, ".ctrl"}, 64'({completed, mem_req, mem_we, load_misaligned, store_misaligned,
                             bus_error, mem_wstrb}), 64'd0);
    chk({tag, ".result"}, 64'(result), 64'd0);
    chk({tag, ".addr"}, 64'(mem_addr), 64'd0);
    chk({tag, ".wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  // Issues one access, plays the bus side, and compares against v.e.
  task automatic run_txn(input string tag, input vec_t v);
    exp_t g;
    int   cyc;
    int   gnt_cyc;
    int   req_seen;
    bit   done;
    bit   req_late;
    g = '0; done = 1'b0; req_late = 1'b0; gnt_cyc = -1; req_seen = 0;
    @(posedge clk); #1;
    enabled = 1'b1; instr_v = instructions'(v.iw);
    reg_v.rs1 = $urandom; reg_v.rs2 = v.rs2; alu_result = v.addr;
    @(posedge clk); #1;
    enabled = 1'b0; instr_v = instructions'($urandom); alu_result = $urandom;
    cyc = 1;
    while (!done && cyc < 400) begin
      if (completed) begin
        g.res = result; g.lm = load_misaligned; g.sm = store_misaligned; g.be = bus_error;
        g.lat = 32'(cyc); done = 1'b1;
      end else begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
        if (mem_req) begin
          if (gnt_cyc >= 0) req_late = 1'b1;
          g.req = 1'b1; g.we = mem_we; g.maddr = mem_addr; g.wdata = mem_wdata; g.wstrb = mem_wstrb;
          mem_rvalid = 1'($urandom_range(0, 1));
          if (req_seen == v.gnt_lat) begin
            mem_gnt = 1'b1; gnt_cyc = cyc;
          end
          req_seen++;
        end
        if (gnt_cyc >= 0 && v.rv_lat >= 0 && cyc == gnt_cyc + 1 + v.rv_lat) begin
          mem_rvalid = 1'b1; mem_rdata = v.rdata;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk({tag, ".done"}, 64'(done), 64'd1);
    if (done) begin
      chk({tag, ".result"}, 64'(g.res), 64'(v.e.res));
      chk({tag, ".flags"}, 64'({g.lm, g.sm, g.be}), 64'({v.e.lm, v.e.sm, v.e.be}));
      chk({tag, ".latency"}, 64'(g.lat), 64'(v.e.lat));
      chk({tag, ".req"}, 64'(g.req), 64'(v.e.req));
      chk({tag, ".req_drop"}, 64'(req_late), 64'd0);
      if (v.e.req) begin
        chk({tag, ".addr"}, 64'(g.maddr), 64'(v.e.maddr));
        chk({tag, ".we"}, 64'(g.we), 64'(v.e.we));
        if (v.e.we) begin
          chk({tag, ".wstrb"}, 64'(g.wstrb), 64'(v.e.wstrb));
          chk({tag, ".wdata"}, 64'(g.wdata), 64'(v.e.wdata));
        end
      end
      @(posedge clk); #1;
      chk({tag, ".pulse"}, 64'(completed), 64'd0);
    end
  endtask

  localparam logic [6:0] LD = 7'h03;
  localparam logic [6:0] ST = 7'h23;
  localparam logic [6:0] OP = 7'h33;

  vec_t        dir [14];
  vec_t        v;
  logic [31:0] ops [9];

  initial begin
    rst = 1'b1; enabled = 1'b0; instr_v = '0; reg_v = '0; alu_result = 32'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;

    dir[0]  = mkv(enc(ST, 3'd2), 32'hDEADBEEF, 32'h100, 32'h0, 0, 0,
                  mke(32'h0, 3'b000, 4, 1'b1, 32'h100, 1'b1, 4'b1111, 32'hDEADBEEF));
    dir[1]  = mkv(enc(LD, 3'd0), 32'h0, 32'h203, 32'h80FF_1234, 0, 0,
                  mke(32'hFFFF_FF80, 3'b000, 4, 1'b1, 32'h200, 1'b0, 4'b0, 32'h0));
    dir[2]  = mkv(enc(LD, 3'd4), 32'h0, 32'h203, 32'h80FF_1234, 0, 0,
                  mke(32'h0000_0080, 3'b000, 4, 1'b1, 32'h200, 1'b0, 4'b0, 32'h0));
    dir[3]  = mkv(enc(LD, 3'd1), 32'h0, 32'h302, 32'h8001_0000, 0, 0,
                  mke(32'hFFFF_8001, 3'b000, 4, 1'b1, 32'h300, 1'b0, 4'b0, 32'h0));
    dir[4]  = mkv(enc(ST, 3'd1), 32'h1234, 32'h302, 32'h0, 0, 0,
                  mke(32'h0, 3'b000, 4, 1'b1, 32'h300, 1'b1, 4'b1100, 32'h1234_1234));
`ifdef MEM_MISALIGN_TRAP_EN
    dir[5]  = mkv(enc(LD, 3'd2), 32'h0, 32'h101, 32'hCAFE_F00D, 0, 0,
                  mke(32'h0, 3'b100, 2, 1'b0, 32'h0, 1'b0, 4'b0, 32'h0));
    dir[12] = mkv(enc(ST, 3'd1), 32'hBEEF, 32'h301, 32'h0, 0, 0,
                  mke(32'h0, 3'b010, 2, 1'b0, 32'h0, 1'b0, 4'b0, 32'h0));
`else
    dir[5]  = mkv(enc(LD, 3'd2), 32'h0, 32'h101, 32'hCAFE_F00D, 0, 0,
                  mke(32'hCAFE_F00D, 3'b000, 4, 1'b1, 32'h100, 1'b0, 4'b0, 32'h0));
    dir[12] = mkv(enc(ST, 3'd1), 32'hBEEF, 32'h301, 32'h0, 0, 0,
                  mke(32'h0, 3'b000, 4, 1'b1, 32'h300, 1'b1, 4'b0011, 32'hBEEF_BEEF));
`endif
    dir[6]  = mkv(enc(OP, 3'd0), 32'h0, 32'h5, 32'h0, 0, 0,
                  mke(32'h5, 3'b000, 2, 1'b0, 32'h0, 1'b0, 4'b0, 32'h0));
    dir[7]  = mkv(enc(LD, 3'd2), 32'h0, 32'h40, 32'h1234_5678, 2, 3,
                  mke(32'h1234_5678, 3'b000, 9, 1'b1, 32'h40, 1'b0, 4'b0, 32'h0));
    dir[8]  = mkv(enc(LD, 3'd2), 32'h0, 32'h44, 32'h1111_1111, 0, -1,
                  mke(32'h0, 3'b001, 258, 1'b1, 32'h44, 1'b0, 4'b0, 32'h0));
    dir[9]  = mkv(enc(LD, 3'd2), 32'h0, 32'h48, 32'h0BAD_CAFE, 0, 254,
                  mke(32'h0BAD_CAFE, 3'b000, 258, 1'b1, 32'h48, 1'b0, 4'b0, 32'h0));
    dir[10] = mkv(enc(LD, 3'd2), 32'h0, 32'h4C, 32'h2222_2222, 0, 255,
                  mke(32'h0, 3'b001, 258, 1'b1, 32'h4C, 1'b0, 4'b0, 32'h0));
    dir[11] = mkv(enc(ST, 3'd0), 32'h1234_56AB, 32'h201, 32'h0, 0, 0,
                  mke(32'h0, 3'b000, 4, 1'b1, 32'h200, 1'b1, 4'b0010, 32'hABAB_ABAB));
    dir[13] = mkv(enc(LD, 3'd5), 32'h0, 32'h302, 32'h8001_0000, 1, 1,
                  mke(32'h0000_8001, 3'b000, 6, 1'b1, 32'h300, 1'b0, 4'b0, 32'h0));

    #12;
    rst_check("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_txn($sformatf("dir%0d", i), dir[i]);
    end

    // Reset while waiting for a response must clear outputs without a clock edge.
    @(posedge clk); #1;
    enabled = 1'b1; instr_v = instructions'(enc(LD, 3'd2)); alu_result = 32'h400;
    @(posedge clk); #1;
    enabled = 1'b0;
    chk("abort.req", 64'(mem_req), 64'd1);
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort.pre_addr", 64'(mem_addr), 64'h400);
    #2;
    rst = 1'b1;
    #1;
    rst_check("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    run_txn("post_rst_add", mkv(enc(OP, 3'd0), 32'h0, 32'h5, 32'h0, 0, 0,
                                mke(32'h5, 3'b000, 2, 1'b0, 32'h0, 1'b0, 4'b0, 32'h0)));

    ops = '{enc(LD, 3'd0), enc(LD, 3'd1), enc(LD, 3'd2), enc(LD, 3'd4), enc(LD, 3'd5),
            enc(ST, 3'd0), enc(ST, 3'd1), enc(ST, 3'd2), enc(OP, 3'd0)};
    for (int i = 0; i < 60; i++) begin
      v.iw      = ops[$urandom_range(0, 8)];
      v.rs2     = $urandom;
      v.addr    = $urandom;
      v.rdata   = $urandom;
      v.gnt_lat = int'($urandom_range(0, 2));
      v.rv_lat  = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(0, 3));
      v.e       = model(v);
      run_txn($sformatf("rnd%0d", i), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
